// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle for the serial magnitude comparator.
// The requester drives start/a/b; the comparator returns status and a one-hot result.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             equal;
    logic             lesser;

    modport master (
        output start, a, b,
        input  busy, done, greater, equal, lesser
    );

    modport slave (
        input  start, a, b,
        output busy, done, greater, equal, lesser
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans MSB first, one bit per clock,
// and stops at the first differing bit with a one-hot result and a done pulse.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             greater_reg;
    logic             equal_reg;
    logic             lesser_reg;

    logic a_bit;
    logic b_bit;

    assign a_bit = a_reg[idx_reg];
    assign b_bit = b_reg[idx_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            greater_reg <= 1'b0;
            equal_reg   <= 1'b0;
            lesser_reg  <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the SCAN exit re-arms it
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg       <= bus.a;
                        b_reg       <= bus.b;
                        idx_reg     <= IDX_W'(WIDTH - 1);
                        greater_reg <= 1'b0;
                        equal_reg   <= 1'b0;
                        lesser_reg  <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SCAN;
                    end
                end
                SCAN: begin
                    if (a_bit && !b_bit) begin
                        greater_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (!a_bit && b_bit) begin
                        lesser_reg  <= 1'b1;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (idx_reg == '0) begin
                        // all bits matched down to the LSB
                        equal_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.greater = greater_reg;
    assign bus.equal   = equal_reg;
    assign bus.lesser  = lesser_reg;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized scoreboard bench for serial_magnitude_comparator (WIDTH=8):
// the driver predicts result and completion edge, a monitor checks every cycle.
module tb_serial_magnitude_comparator;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    serial_magnitude_comparator_if #(.WIDTH(W)) bus ();

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   code;     // {greater, equal, lesser}
        int           done_at;  // edge count after which done is visible
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   last_done_edge = 0;
    logic [2:0] held = 3'b000;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference: result from plain unsigned arithmetic; latency from the
    // position of the most significant differing bit.
    function automatic logic [2:0] ref_code(input logic [W-1:0] av, input logic [W-1:0] bv);
        int ai = int'(av);
        int bi = int'(bv);
        if (ai > bi) return 3'b100;
        if (ai == bi) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
        int x = int'(av ^ bv);
        if (x == 0) return W;
        return W - ($clog2(x + 1) - 1);
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s at edge %0d: got {busy,done,g,e,l}=%b required %b",
                         name, cyc, act[4:0], req[4:0]);
        end
    endtask

    // Drive one cycle of start at the current negedge; queue an expectation
    // only if the comparator is idle per the model.
    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        if (!rst && cyc >= last_done_edge) begin
            e.a       = av;
            e.b       = bv;
            e.code    = ref_code(av, bv);
            e.lat     = ref_lat(av, bv);
            e.done_at = cyc + 1 + e.lat;
            last_done_edge = e.done_at;
            sb.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
        end
    endtask

    task automatic wait_free();
        int guard = 0;
        while (cyc < last_done_edge && guard < 4 * W) begin
            idle_cycles(1);
            guard++;
        end
    endtask

    // Monitor: every cycle, compare busy/done/results against the model.
    initial begin
        logic [5:0] req;
        logic [5:0] act;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            req = '0;
            if (!rst) begin
                if (sb.size() > 0 && sb[0].done_at == cyc) begin
                    e = sb.pop_front();
                    held = e.code;
                    n_txn++;
                    $display("txn %0d: a=%02h b=%02h result(g,e,l)=%b latency=%0d",
                             n_txn, e.a, e.b, e.code, e.lat);
                    req = {2'b00, 1'b1, e.code};
                end else if (cyc < last_done_edge) begin
                    req = 6'b010000;
                end else begin
                    req = {3'b000, held};
                end
            end
            act = {1'b0, bus.busy, bus.done, bus.greater, bus.equal, bus.lesser};
            check("cycle_outputs", act, req);
        end
    end

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int guard;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clk);
        check("reset_state", {1'b0, bus.busy, bus.done, bus.greater, bus.equal, bus.lesser}, 6'b0);
        rst = 1'b0;

        // 1: MSB decides, one-cycle latency
        @(negedge clk); drive(8'h80, 8'h7F);
        idle_cycles(1); wait_free(); idle_cycles(1);
        // 2: LSB decides, lesser
        @(negedge clk); drive(8'h12, 8'h13);
        idle_cycles(1); wait_free(); idle_cycles(1);
        // 3: equal operands, results held through idle cycles
        @(negedge clk); drive(8'hA5, 8'hA5);
        idle_cycles(1); wait_free(); idle_cycles(5);
        // 4: start while busy is ignored
        @(negedge clk); drive(8'h0F, 8'h0E);
        idle_cycles(1);
        @(negedge clk); drive(8'hFF, 8'h00);
        idle_cycles(1); wait_free(); idle_cycles(1);

        // 5: asynchronous reset mid-scan aborts with no done
        @(negedge clk); drive(8'h00, 8'h01);
        idle_cycles(3);
        #2 rst = 1'b1;
        #1 check("async_reset", {1'b0, bus.busy, bus.done, bus.greater, bus.equal, bus.lesser}, 6'b0);
        sb.delete();
        last_done_edge = 0;
        held = 3'b000;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(W + 2);
        @(negedge clk); drive(8'h3C, 8'h3C);
        idle_cycles(1); wait_free(); idle_cycles(1);

        // 6: randomized back-to-back with start held high throughout
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            av = W'($urandom);
            case ($urandom_range(0, 7))
                0, 1:    bv = av;
                2, 3:    bv = av ^ W'(1 << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            drive(av, bv);
        end
        idle_cycles(1);

        guard = 0;
        while (sb.size() > 0 && guard < 4 * W) begin
            idle_cycles(1);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
